// File: rtl/mult_result_buffer_pkg.sv
// ----------------------------------------------------------------------------
// mult_result_buffer_pkg
// Definitions shared by the shift-add multiplier control machine and the
// result buffer that sits downstream of it.
//   OPERAND_W  : multiplier operand width (32)
//   PRODUCT_W  : product width, twice the operand width (64)
//   capState_e : handshake state encodings (IDLE / ACK / WAIT)
// ----------------------------------------------------------------------------
package mult_result_buffer_pkg;

  localparam int OPERAND_W = 32;
  localparam int PRODUCT_W = 2 * OPERAND_W;

  // WAIT is reserved; the control machine and this buffer share the encoding
  // so that both sides agree on the state values.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } capState_e;

endpackage : mult_result_buffer_pkg

// File: rtl/mult_result_buffer_sync_fifo_fwft.sv
// ----------------------------------------------------------------------------
// sync_fifo_fwft
// Single-clock first-word-fall-through FIFO. The head entry is visible on
// dout whenever the FIFO is not empty; pop consumes it at the next edge.
// Ports:
//   Clock, Reset : clock and synchronous active-high reset
//   push, din    : write din at the tail (ignored while full)
//   pop          : consume the head entry (ignored while empty)
//   dout         : head entry, forced to 0 while empty
//   count        : occupied entries, 0..DEPTH
//   full, empty  : status derived from the registered count
// ----------------------------------------------------------------------------
module sync_fifo_fwft #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [PTR_W:0]   count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  // Full is judged on the registered count, so a push against a full FIFO is
  // refused even when a pop happens on the same edge.
  assign full   = (count == (PTR_W+1)'(DEPTH));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign dout   = empty ? '0 : mem[rdPtr];

  // Pointers wrap naturally because DEPTH is a power of two; the extra count
  // bit is what tells full from empty.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale words are unreachable
  // because dout is masked while empty and the pointers restart at zero.
  always_ff @(posedge Clock) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule : sync_fifo_fwft

// File: rtl/mult_result_buffer.sv
// ----------------------------------------------------------------------------
// mult_result_buffer
// Captures finished products from the shift-add multiplier over a 4-phase
// done/ack handshake and queues them in a FWFT FIFO for a valid/ready
// consumer, so the multiplier can start its next operation early.
// Ports:
//   Clock, Reset : clock and synchronous active-high reset
//   iDone        : product on iProduct is stable; held until oAck is seen
//   iProduct     : product from the datapath, stored bit-exact
//   oAck         : product captured (high for the whole ACK state)
//   oData        : head-of-FIFO product, 0 when empty
//   oValid       : FIFO not empty
//   iReady       : consumer takes oData this cycle
//   oCount       : occupied entries, 0..DEPTH
//   oFull        : oCount == DEPTH
//   oStall       : a product is waiting but the FIFO is full
// ----------------------------------------------------------------------------
module mult_result_buffer
  import mult_result_buffer_pkg::*;
#(
  parameter  int WIDTH = PRODUCT_W,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iDone,
  input  logic [WIDTH-1:0] iProduct,
  output logic             oAck,
  output logic [WIDTH-1:0] oData,
  output logic             oValid,
  input  logic             iReady,
  output logic [PTR_W:0]   oCount,
  output logic             oFull,
  output logic             oStall
);

  capState_e state;
  capState_e nextState;
  logic      fifoPush;
  logic      fifoEmpty;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, regardless of block ordering.
  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  // One write per iDone assertion: the write happens only on the IDLE->ACK
  // transition, and ACK is held until iDone drops.
  always_comb begin
    // NOTE: defaults first, so no path through the case leaves a signal
    // unassigned and infers a latch.
    nextState = state;
    fifoPush  = 1'b0;
    case (state)
      IDLE: begin
        if (iDone && !oFull) begin
          fifoPush  = 1'b1;
          nextState = ACK;
        end
      end
      ACK: begin
        if (!iDone) nextState = IDLE;
      end
      default: nextState = IDLE; // WAIT and the unused code recover to IDLE
    endcase
  end

  // The state is registered, so this decode is a clean registered ack.
  assign oAck   = (state == ACK);
  assign oValid = !fifoEmpty;
  // Stall only reports a capture that is actually being refused; while in ACK
  // the pending product has already been taken.
  assign oStall = iDone && oFull && (state == IDLE);

  sync_fifo_fwft #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .Clock (Clock),
    .Reset (Reset),
    .push  (fifoPush),
    .pop   (iReady),
    .din   (iProduct),
    .dout  (oData),
    .count (oCount),
    .full  (oFull),
    .empty (fifoEmpty)
  );

endmodule : mult_result_buffer

// File: tb/tb_mult_result_buffer.sv
// ----------------------------------------------------------------------------
// tb_mult_result_buffer
// Self-checking bench: products are pushed to an expected queue when they are
// offered on iDone and popped when the consumer side takes them.
// ----------------------------------------------------------------------------
module tb_mult_result_buffer;

  localparam int WIDTH = 64;
  localparam int DEPTH = 4;

  logic             Clock;
  logic             Reset;
  logic             iDone;
  logic [WIDTH-1:0] iProduct;
  logic             oAck;
  logic [WIDTH-1:0] oData;
  logic             oValid;
  logic             iReady;
  logic [2:0]       oCount;
  logic             oFull;
  logic             oStall;

  logic [WIDTH-1:0] sbq[$];
  logic [WIDTH-1:0] expData;
  int compared   = 0;
  int mismatched = 0;

  mult_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .iDone    (iDone),
    .iProduct (iProduct),
    .oAck     (oAck),
    .oData    (oData),
    .oValid   (oValid),
    .iReady   (iReady),
    .oCount   (oCount),
    .oFull    (oFull),
    .oStall   (oStall)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Advance one edge; outputs are then sampled 1 time unit after it.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Offer one product and complete the 4-phase handshake (bounded waits).
  task automatic handshake(input logic [WIDTH-1:0] prod);
    int waited;
    iDone    = 1'b1;
    iProduct = prod;
    sbq.push_back(prod);
    waited = 0;
    tick();
    while (!oAck && waited < 20) begin
      tick();
      waited++;
    end
    compared++;
    if (oAck !== 1'b1) begin
      mismatched++;
      $display("FAIL handshake_ack prod=%0h: oAck=%b required 1 within 20 cycles", prod, oAck);
    end
    iDone = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    Reset = 1'b1; iDone = 1'b0; iReady = 1'b0; iProduct = '0;
    tick(); tick();
    Reset = 1'b0;
    sbq.delete();
    compared++;
    if ({oAck, oValid, oFull, oStall} !== 4'b0000) begin
      mismatched++;
      $display("FAIL reset_flags: ack/valid/full/stall=%b required 0000", {oAck, oValid, oFull, oStall});
    end
    compared++;
    if (oData !== '0 || oCount !== 3'd0) begin
      mismatched++;
      $display("FAIL reset_data: oData=%0h oCount=%0d required 0/0", oData, oCount);
    end
  endtask

  // Consume everything with iReady high, checking order against the queue.
  task automatic test_drain();
    int cycles;
    iReady = 1'b1;
    cycles = 0;
    while ((oValid || sbq.size() != 0) && cycles < 20) begin
      compared++;
      if (!oValid || sbq.size() == 0) begin
        mismatched++;
        $display("FAIL drain_valid: oValid=%b queued=%0d", oValid, sbq.size());
        if (sbq.size() != 0) void'(sbq.pop_front());
      end else begin
        expData = sbq.pop_front();
        if (oData !== expData) begin
          mismatched++;
          $display("FAIL drain_data: oData=%0h required %0h", oData, expData);
        end
      end
      tick();
      cycles++;
    end
    iReady = 1'b0;
    compared++;
    if (oValid !== 1'b0 || oData !== '0 || oCount !== 3'd0) begin
      mismatched++;
      $display("FAIL drain_empty: oValid=%b oData=%0h oCount=%0d required 0/0/0", oValid, oData, oCount);
    end
  endtask

  task automatic test_single();
    iReady = 1'b0; iDone = 1'b1; iProduct = 64'd160;
    sbq.push_back(64'd160);
    tick();
    compared++;
    if (oAck !== 1'b1 || oValid !== 1'b1 || oCount !== 3'd1) begin
      mismatched++;
      $display("FAIL single_capture: ack=%b valid=%b count=%0d required 1/1/1", oAck, oValid, oCount);
    end
    compared++;
    if (oData !== 64'd160) begin
      mismatched++;
      $display("FAIL single_data: oData=%0d required 160", oData);
    end
    iDone = 1'b0;
    tick();
    compared++;
    if (oAck !== 1'b0) begin
      mismatched++;
      $display("FAIL single_ack_drop: oAck=%b required 0", oAck);
    end
    test_drain();
  endtask

  task automatic test_long_hold();
    iReady = 1'b0; iDone = 1'b1; iProduct = 64'hFFFF_FFFE_0000_0001;
    sbq.push_back(64'hFFFF_FFFE_0000_0001);
    for (int i = 0; i < 10; i++) begin
      tick();
      compared++;
      if (oAck !== 1'b1 || oCount !== 3'd1) begin
        mismatched++;
        $display("FAIL long_hold cycle %0d: oAck=%b oCount=%0d required 1/1", i, oAck, oCount);
      end
    end
    iDone = 1'b0;
    tick();
    compared++;
    if (oAck !== 1'b0 || oCount !== 3'd1) begin
      mismatched++;
      $display("FAIL long_hold_release: oAck=%b oCount=%0d required 0/1", oAck, oCount);
    end
    test_drain();
  endtask

  task automatic test_fill_stall();
    iReady = 1'b0;
    for (int p = 1; p <= 4; p++) handshake(WIDTH'(p));
    compared++;
    if (oFull !== 1'b1 || oCount !== 3'd4) begin
      mismatched++;
      $display("FAIL fill_full: oFull=%b oCount=%0d required 1/4", oFull, oCount);
    end
    iDone = 1'b1; iProduct = 64'd5;
    sbq.push_back(64'd5);
    tick();
    compared++;
    if (oStall !== 1'b1 || oAck !== 1'b0 || oCount !== 3'd4) begin
      mismatched++;
      $display("FAIL fill_stall: oStall=%b oAck=%b oCount=%0d required 1/0/4", oStall, oAck, oCount);
    end
    // One pop: the push stays blocked this edge (registered full), lands next.
    iReady = 1'b1;
    expData = sbq.pop_front();
    compared++;
    if (oData !== expData) begin
      mismatched++;
      $display("FAIL fill_head: oData=%0h required %0h", oData, expData);
    end
    tick();
    iReady = 1'b0;
    compared++;
    if (oStall !== 1'b0 || oAck !== 1'b0 || oCount !== 3'd3) begin
      mismatched++;
      $display("FAIL fill_after_pop: oStall=%b oAck=%b oCount=%0d required 0/0/3", oStall, oAck, oCount);
    end
    tick();
    compared++;
    if (oAck !== 1'b1 || oCount !== 3'd4) begin
      mismatched++;
      $display("FAIL fill_late_capture: oAck=%b oCount=%0d required 1/4", oAck, oCount);
    end
    iDone = 1'b0;
    tick();
    test_drain();
  endtask

  task automatic test_back_to_back();
    iReady = 1'b0;
    handshake(64'd10);
    handshake(64'd11);
    iDone = 1'b1; iProduct = 64'd7; iReady = 1'b1;
    sbq.push_back(64'd7);
    expData = sbq.pop_front();
    compared++;
    if (oData !== expData || oCount !== 3'd2) begin
      mismatched++;
      $display("FAIL b2b_before: oData=%0h oCount=%0d required %0h/2", oData, oCount, expData);
    end
    tick();
    iReady = 1'b0;
    compared++;
    if (oCount !== 3'd2 || oAck !== 1'b1 || oData !== sbq[0]) begin
      mismatched++;
      $display("FAIL b2b_after: oCount=%0d oAck=%b oData=%0h required 2/1/%0h", oCount, oAck, oData, sbq[0]);
    end
    iDone = 1'b0;
    tick();
    test_drain();
  endtask

  task automatic test_reset_mid();
    iReady = 1'b0;
    handshake(64'd20);
    handshake(64'd21);
    iDone = 1'b1; iProduct = 64'd22;
    sbq.push_back(64'd22);
    tick();
    compared++;
    if (oAck !== 1'b1 || oCount !== 3'd3) begin
      mismatched++;
      $display("FAIL mid_setup: oAck=%b oCount=%0d required 1/3", oAck, oCount);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0; iDone = 1'b0;
    sbq.delete();
    compared++;
    if (oValid !== 1'b0 || oCount !== 3'd0 || oAck !== 1'b0 || oData !== '0) begin
      mismatched++;
      $display("FAIL mid_reset: oValid=%b oCount=%0d oAck=%b oData=%0h required 0/0/0/0", oValid, oCount, oAck, oData);
    end
    handshake(64'd42);
    compared++;
    if (oData !== 64'd42 || oCount !== 3'd1) begin
      mismatched++;
      $display("FAIL mid_recover: oData=%0d oCount=%0d required 42/1", oData, oCount);
    end
    test_drain();
  endtask

  initial begin
    test_reset();
    test_single();
    test_long_hold();
    test_fill_stall();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule : tb_mult_result_buffer
